// File: rtl/weight_loader_param.sv
// Loads a run-time sized block of W-bit weights from a read-only BRAM into a flat bus.
// Each read carries a valid tag through a READ_LATENCY-deep shift register to its capture.
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last (possibly partial) result
// ISSUE | one BRAM read per cycle until N reads are issued
// DRAIN | waiting for the remaining tagged reads to land
// DONE  | load complete, data_out stable until the next start
module weight_loader_param #(
    parameter int W             = 8,
    parameter int IN_SIZE       = 256,
    parameter int OUT_SIZE      = 8,
    parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
    parameter int ADDR_WIDTH    = 15,
    parameter int READ_LATENCY  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [ADDR_WIDTH:0]         num_words,
    output logic                        bram_en,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    input  logic [W-1:0]                bram_dout,
    output logic [TOTAL_WEIGHTS*W-1:0]  data_out,
    output logic [ADDR_WIDTH:0]         words_loaded,
    output logic                        busy,
    output logic                        done
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_WEIGHTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [CNT_W-1:0]        n_words;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        n_req;
    logic [READ_LATENCY-1:0] vld;
    logic [READ_LATENCY:0]   vld_ext;
    logic [READ_LATENCY-1:0] vld_next;
    logic                    capture;
    logic [CNT_W-1:0]        wl_next;

    always_comb begin
        n_req    = (num_words > TOTAL_C) ? TOTAL_C : num_words;
        vld_ext  = {vld, bram_en};
        vld_next = vld_ext[READ_LATENCY-1:0];
        capture  = vld[READ_LATENCY-1];
        wl_next  = words_loaded + CNT_W'(capture);
    end

    assign busy = (state == S_ISSUE) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bram_en      <= 1'b0;
            bram_addr    <= '0;
            data_out     <= '0;
            words_loaded <= '0;
            n_words      <= '0;
            issue_cnt    <= '0;
            vld          <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_words      <= n_req;
                        data_out     <= '0;
                        words_loaded <= '0;
                        vld          <= '0;
                        bram_addr    <= base_addr;
                        issue_cnt    <= CNT_W'(1);
                        // An empty request passes through DRAIN so done still rises a cycle later.
                        if (n_req != '0) begin
                            state   <= S_ISSUE;
                            bram_en <= 1'b1;
                        end else begin
                            state   <= S_DRAIN;
                            bram_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        bram_en <= 1'b0;
                        vld     <= '0;
                    end else begin
                        vld <= vld_next;
                        if (capture) begin
                            words_loaded <= wl_next;
                            for (int i = 0; i < TOTAL_WEIGHTS; i++) begin
                                if (words_loaded == CNT_W'(i))
                                    data_out[i*W +: W] <= bram_dout;
                            end
                        end
                        if (state == S_ISSUE) begin
                            if (issue_cnt == n_words) begin
                                bram_en <= 1'b0;
                                state   <= S_DRAIN;
                            end else begin
                                bram_addr <= bram_addr + 1'b1;
                                issue_cnt <= issue_cnt + 1'b1;
                            end
                        end else if (vld_next == '0 && wl_next == n_words) begin
                            state <= S_DONE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
